// File: rtl/mm_sched.sv
// mm_sched: job sequencer for the mm systolic matrix-multiply wrapper.
// It loads activations and bit-serial weights from two synchronous scratch
// memories into mm's FIFOs. It then drives `active` for K*precision cycles
// and waits for mm's `done`, with a timeout.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start                    job request (sampled only in IDLE)
//   precision_in, exp_in     job configuration
//   busy, done, err          host status (done/err are one-cycle pulses)
//   act_re, act_addr         activation memory read port
//   act_rdata                activation read data (one cycle after act_re)
//   w_re, w_addr             weight memory read port
//   w_rdata                  weight read data (one cycle after w_re)
//   act_din, wr_en_act       activation FIFO write to mm
//   w_din, wr_en_w           weight FIFO write to mm
//   active                   compute enable to mm
//   precision, exp_set       latched job configuration to mm
//   mm_done                  completion from mm
module mm_sched #(
   parameter int unsigned ACT_WIDTH = 16,
   parameter int unsigned N         = 2,
   parameter int unsigned K         = 2,
   parameter int unsigned MAX_P     = 8,
   parameter int unsigned GAP_CYC   = 2,
   parameter int unsigned TIMEOUT   = 256,
   parameter int unsigned AW        = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [3:0]             precision_in,
   input  logic [4:0]             exp_in,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic                   act_re,
   output logic [AW-1:0]          act_addr,
   input  logic [N*ACT_WIDTH-1:0] act_rdata,
   output logic                   w_re,
   output logic [AW-1:0]          w_addr,
   input  logic [N-1:0]           w_rdata,
   output logic [N*ACT_WIDTH-1:0] act_din,
   output logic                   wr_en_act,
   output logic [N-1:0]           w_din,
   output logic                   wr_en_w,
   output logic                   active,
   output logic [3:0]             precision,
   output logic [4:0]             exp_set,
   input  logic                   mm_done
);

   localparam int unsigned KP_MAX = K * MAX_P;
   // One counter serves LOAD_ACT, LOAD_W, GAP and RUN.
   localparam int unsigned CW     = $clog2(KP_MAX + GAP_CYC + 2);
   localparam int unsigned TW     = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_ACT,
      LOAD_W,
      GAP,
      RUN,
      WAIT_DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] kp_last;
   logic [TW-1:0] tcnt;
   logic          legal_c;

   // Precision must lie in 1..MAX_P.
   assign legal_c = (precision_in != 4'd0) && (32'(precision_in) <= MAX_P);

   // The memories register their read data, so write data is the read return
   // qualified by the one-cycle-delayed read enable.
   assign act_din = wr_en_act ? act_rdata : '0;
   assign w_din   = wr_en_w   ? w_rdata   : '0;

   // Sequencer state, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         kp_last   <= '0;
         tcnt      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         act_re    <= 1'b0;
         act_addr  <= '0;
         w_re      <= 1'b0;
         w_addr    <= '0;
         wr_en_act <= 1'b0;
         wr_en_w   <= 1'b0;
         active    <= 1'b0;
         precision <= '0;
         exp_set   <= '0;
      end else begin
         done      <= 1'b0;
         err       <= 1'b0;
         wr_en_act <= act_re;
         wr_en_w   <= w_re;

         case (state)
            IDLE: begin
               if (start) begin
                  if (legal_c) begin
                     precision <= precision_in;
                     exp_set   <= exp_in;
                     kp_last   <= CW'(K) * CW'(precision_in) - CW'(1);
                     busy      <= 1'b1;
                     cnt       <= '0;
                     state     <= LOAD_ACT;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end

            LOAD_ACT: begin
               act_re   <= 1'b1;
               act_addr <= AW'(cnt);
               if (cnt == CW'(K - 1)) begin
                  cnt   <= '0;
                  state <= LOAD_W;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            // Weight address k*precision+p is a plain linear count; it wraps
            // modulo 2^AW by truncation.
            LOAD_W: begin
               act_re <= 1'b0;
               w_re   <= 1'b1;
               w_addr <= AW'(cnt);
               if (cnt == kp_last) begin
                  cnt   <= '0;
                  state <= GAP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            // First cycle drains the last weight write, then GAP_CYC idle cycles.
            GAP: begin
               w_re <= 1'b0;
               if (cnt == CW'(GAP_CYC + 1)) begin
                  active <= 1'b1;
                  cnt    <= '0;
                  state  <= RUN;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            RUN: begin
               if (cnt == kp_last) begin
                  active <= 1'b0;
                  cnt    <= '0;
                  tcnt   <= '0;
                  state  <= WAIT_DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            // mm_done wins over a timeout expiring in the same cycle.
            WAIT_DONE: begin
               if (mm_done) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (tcnt == TW'(TIMEOUT - 1)) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mm_sched.sv
// tb_mm_sched: directed bench for mm_sched with synchronous memory models.
// Job traces are captured per cycle (cycle 0 = the cycle after start is
// sampled) and compared against hand-derived signal windows.
module tb_mm_sched;

   localparam int unsigned AW  = 8;
   localparam int unsigned NC  = 300;

   // Bit positions inside a trace word.
   localparam int S_ARE = 0;
   localparam int S_WEA = 1;
   localparam int S_WRE = 2;
   localparam int S_WEW = 3;
   localparam int S_ACT = 4;
   localparam int S_BSY = 5;
   localparam int S_DON = 6;
   localparam int S_ERR = 7;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [3:0]    precision_in;
   logic [4:0]    exp_in;
   logic          busy, done, err;
   logic          act_re, w_re;
   logic [AW-1:0] act_addr, w_addr;
   logic [31:0]   act_rdata;
   logic [1:0]    w_rdata;
   logic [31:0]   act_din;
   logic          wr_en_act;
   logic [1:0]    w_din;
   logic          wr_en_w;
   logic          active;
   logic [3:0]    precision;
   logic [4:0]    exp_set;
   logic          mm_done;

   mm_sched dut (
      .clk(clk), .rst(rst), .start(start),
      .precision_in(precision_in), .exp_in(exp_in),
      .busy(busy), .done(done), .err(err),
      .act_re(act_re), .act_addr(act_addr), .act_rdata(act_rdata),
      .w_re(w_re), .w_addr(w_addr), .w_rdata(w_rdata),
      .act_din(act_din), .wr_en_act(wr_en_act),
      .w_din(w_din), .wr_en_w(wr_en_w),
      .active(active), .precision(precision), .exp_set(exp_set),
      .mm_done(mm_done)
   );

   always #5 clk = ~clk;

   // Scratch memory models: registered read data.
   logic [31:0] act_mem [0:3];
   logic [1:0]  w_mem   [0:15];
   always @(posedge clk) begin
      if (act_re) act_rdata <= act_mem[act_addr[1:0]];
      if (w_re)   w_rdata   <= w_mem[w_addr[3:0]];
   end

   // Per-cycle traces.
   logic [7:0]    tr [0:NC-1];
   logic [AW-1:0] aa [0:NC-1];
   logic [AW-1:0] wa [0:NC-1];
   logic [31:0]   ad [0:NC-1];
   logic [1:0]    wd [0:NC-1];
   logic [3:0]    pr [0:NC-1];
   logic [4:0]    ex [0:NC-1];

   typedef struct {
      int sig;
      int lo;
      int hi;
   } win_t;

   typedef struct {
      logic [3:0] p;
      logic [4:0] e;
      logic       acc;
   } st_t;

   win_t  wins [0:2][0:7];
   st_t   stv  [0:4];
   string sname [0:7];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", nm, got, exp);
      end
   endtask

   // Run one job at P=4, exp=15 and record ncyc cycles. Optional events
   // (-1 = none) at cycle c take effect at the following edge.
   task automatic run_job(input int ncyc, input int done_cyc, input int start2_cyc,
                          input int rst_cyc);
      precision_in = 4'd4;
      exp_in       = 5'd15;
      start        = 1'b1;
      @(posedge clk); #1;
      for (int c = 0; c < ncyc; c++) begin
         tr[c] = {err, done, busy, active, wr_en_w, w_re, wr_en_act, act_re};
         aa[c] = act_addr;
         wa[c] = w_addr;
         ad[c] = act_din;
         wd[c] = w_din;
         pr[c] = precision;
         ex[c] = exp_set;
         start   = (c == start2_cyc);
         mm_done = (c == done_cyc);
         rst     = (c == rst_cyc);
         if (c == start2_cyc) begin
            precision_in = 4'd2;
            exp_in       = 5'd3;
         end
         @(posedge clk); #1;
      end
      start   = 1'b0;
      mm_done = 1'b0;
      rst     = 1'b0;
   endtask

   task automatic check_wins(input int s, input int ncyc, input string tag);
      for (int i = 0; i < 8; i++) begin
         int   bad;
         int   first;
         logic want;
         bad   = 0;
         first = -1;
         for (int c = 0; c < ncyc; c++) begin
            want = (c >= wins[s][i].lo) && (c <= wins[s][i].hi);
            if (tr[c][wins[s][i].sig] !== want) begin
               bad++;
               if (first < 0) first = c;
            end
         end
         n_tests++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL %s %s: %0d cycles wrong, first at cycle %0d (got %b, want %b)",
                     tag, sname[wins[s][i].sig], bad, first,
                     tr[first][wins[s][i].sig], ~tr[first][wins[s][i].sig]);
         end
      end
   endtask

   // Addresses, FIFO data and latched config of a nominal P=4 job.
   task automatic check_data(input int ncyc, input string tag);
      int bad_a;
      int bad_d;
      bad_a = 0;
      bad_d = 0;
      for (int c = 1; c <= 2; c++)  if (aa[c] !== AW'(c - 1)) bad_a++;
      for (int c = 3; c <= 10; c++) if (wa[c] !== AW'(c - 3)) bad_a++;
      for (int c = 0; c < ncyc; c++) begin
         logic [31:0] ea;
         logic [1:0]  ew;
         ea = (c >= 2 && c <= 3)  ? act_mem[c - 2] : 32'h0;
         ew = (c >= 4 && c <= 11) ? w_mem[c - 4]   : 2'b00;
         if (ad[c] !== ea || wd[c] !== ew) bad_d++;
      end
      check({tag, " address errors"}, 32'(bad_a), 32'd0);
      check({tag, " fifo data errors"}, 32'(bad_d), 32'd0);
      check({tag, " precision"}, 32'(pr[ncyc - 1]), 32'd4);
      check({tag, " exp_set"}, 32'(ex[ncyc - 1]), 32'd15);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      sname = '{"act_re", "wr_en_act", "w_re", "wr_en_w", "active", "busy", "done", "err"};

      // Scenario 0: nominal, mm_done at cycle 30.
      wins[0] = '{'{S_ARE, 1, 2}, '{S_WEA, 2, 3}, '{S_WRE, 3, 10}, '{S_WEW, 4, 11},
                  '{S_ACT, 14, 21}, '{S_BSY, 0, 30}, '{S_DON, 31, 31}, '{S_ERR, -1, -1}};
      // Scenario 1: mm_done never arrives.
      wins[1] = '{'{S_ARE, 1, 2}, '{S_WEA, 2, 3}, '{S_WRE, 3, 10}, '{S_WEW, 4, 11},
                  '{S_ACT, 14, 21}, '{S_BSY, 0, 277}, '{S_DON, -1, -1}, '{S_ERR, 278, 278}};
      // Scenario 2: reset asserted during cycle 6.
      wins[2] = '{'{S_ARE, 1, 2}, '{S_WEA, 2, 3}, '{S_WRE, 3, 6}, '{S_WEW, 4, 6},
                  '{S_ACT, -1, -1}, '{S_BSY, 0, 6}, '{S_DON, -1, -1}, '{S_ERR, -1, -1}};

      stv = '{'{4'd0, 5'd7, 1'b0}, '{4'd9, 5'd1, 1'b0}, '{4'd15, 5'd2, 1'b0},
              '{4'd1, 5'd3, 1'b1}, '{4'd8, 5'd31, 1'b1}};

      act_mem = '{32'hA001_B002, 32'hC003_D004, 32'h1234_5678, 32'h9ABC_DEF0};
      for (int i = 0; i < 16; i++) w_mem[i] = 2'(i * 3 + 1);

      rst = 1'b1; start = 1'b0; mm_done = 1'b0;
      precision_in = 4'd0; exp_in = 5'd0;
      idle(3);

      // Reset state.
      check("reset status", {29'd0, busy, done, err}, 32'd0);
      check("reset reads", {30'd0, act_re, w_re}, 32'd0);
      check("reset writes", {30'd0, wr_en_act, wr_en_w}, 32'd0);
      check("reset active", 32'(active), 32'd0);
      check("reset config", {23'd0, precision, exp_set}, 32'd0);
      check("reset addr", {16'd0, act_addr, w_addr}, 32'd0);
      rst = 1'b0;
      idle(2);

      // Start acceptance table.
      for (int i = 0; i < 5; i++) begin
         int reads;
         int errs;
         int bsy;
         string tag;
         tag = $sformatf("start p=%0d", stv[i].p);
         precision_in = stv[i].p;
         exp_in       = stv[i].e;
         start        = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         check({tag, " err"}, 32'(err), 32'(!stv[i].acc));
         check({tag, " busy"}, 32'(busy), 32'(stv[i].acc));
         reads = 0; errs = 0; bsy = 0;
         for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            reads += int'(act_re | w_re);
            errs  += int'(err);
            bsy   += int'(busy);
         end
         check({tag, " extra err"}, 32'(errs), 32'd0);
         if (stv[i].acc) begin
            check({tag, " reads started"}, 32'(reads != 0), 32'd1);
            check({tag, " latched"}, {23'd0, precision, exp_set}, {23'd0, stv[i].p, stv[i].e});
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check({tag, " cleared"}, {22'd0, busy, precision, exp_set}, 32'd0);
         end else begin
            check({tag, " reads"}, 32'(reads), 32'd0);
            check({tag, " busy later"}, 32'(bsy), 32'd0);
         end
         idle(2);
      end

      // Nominal job.
      run_job(40, 30, -1, -1);
      check_wins(0, 40, "nominal");
      check_data(40, "nominal");
      idle(3);

      // Second start during RUN is ignored.
      run_job(40, 30, 16, -1);
      check_wins(0, 40, "restart");
      check_data(40, "restart");
      idle(3);

      // Timeout, then a new start must be accepted.
      run_job(285, -1, -1, -1);
      check_wins(1, 285, "timeout");
      check_data(285, "timeout");
      idle(2);
      run_job(40, 30, -1, -1);
      check_wins(0, 40, "after timeout");
      check_data(40, "after timeout");
      idle(3);

      // Reset in LOAD_W, then a full job.
      run_job(12, -1, -1, 6);
      check_wins(2, 12, "reset mid");
      check("reset mid outputs c7", 32'(tr[7]), 32'd0);
      check("reset mid config c7", {23'd0, pr[7], ex[7]}, 32'd0);
      check("reset mid addr c7", {16'd0, aa[7], wa[7]}, 32'd0);
      check("reset mid data c7", ad[7] | 32'(wd[7]), 32'd0);
      idle(2);
      run_job(40, 30, -1, -1);
      check_wins(0, 40, "after reset");
      check_data(40, "after reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mm_sched.md
Name: mm_sched

Overview:
- Sequencer for the `mm` systolic matrix-multiply wrapper.
- On `start`, fetches activations and bit-serial weights from two synchronous scratch memories and pushes them into `mm`'s activation and weight FIFOs.
- Then asserts `active` for exactly K*precision cycles and waits for `mm`'s `done`.
- Reports completion or a timeout to the host.

Parameters:
- ACT_WIDTH, 16, activation word width.
- N, 2, array dimension (rows = columns = N).
- K, 2, reduction length (activations per row).
- MAX_P, 8, largest legal weight precision in bits.
- GAP_CYC, 2, idle cycles between the last weight write and the first active cycle.
- TIMEOUT, 256, cycles allowed in WAIT_DONE before an error is raised.
- AW, 8, address width of both scratch memories.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle request; sampled only in IDLE.
- precision_in  in  4  weight precision for this job.
- exp_in  in  5  exponent setting for this job.
- busy  out  1  high from accept until return to IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on rejected start or timeout.
- act_re  out  1  activation memory read enable.
- act_addr  out  AW  activation address; address k returns column k for all N rows.
- act_rdata  in  N*ACT_WIDTH  activation data, valid the cycle after act_re; lane r = row r.
- w_re  out  1  weight memory read enable.
- w_addr  out  AW  weight address = k*precision + p.
- w_rdata  in  N  weight bit per column, valid the cycle after w_re.
- act_din  out  N*ACT_WIDTH  to `mm` activation FIFOs.
- wr_en_act  out  1  to `mm`.
- w_din  out  N  to `mm` weight FIFOs.
- wr_en_w  out  1  to `mm`.
- active  out  1  to `mm`.
- precision  out  4  latched precision, to `mm`.
- exp_set  out  5  latched exponent, to `mm`.
- mm_done  in  1  `done` from `mm`.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0. The same holds when `rst` is asserted mid-job; the job is abandoned and no `done` or `err` is issued.
- States: IDLE, LOAD_ACT, LOAD_W, GAP, RUN, WAIT_DONE.
- **IDLE**
  - `start` with 1 <= precision_in <= MAX_P: latch `precision`/`exp_set`, set `busy`, go to LOAD_ACT.
  - `start` with illegal precision: `err` pulses the next cycle, stay in IDLE.
  - `start` outside IDLE: ignored.
- **LOAD_ACT**
  - `act_re`=1 with `act_addr` = 0..K-1 on consecutive cycles.
  - Go to LOAD_W after the last address is issued.
- **Activation write pipeline**
  - `wr_en_act`/`act_din` are the registered read return: `wr_en_act` is high the cycle after each `act_re`, with `act_din` = `act_rdata`.
  - The final activation write overlaps the first LOAD_W cycle.
- **LOAD_W**
  - `w_re`=1 with `w_addr` = 0..K*precision-1 on consecutive cycles.
  - `wr_en_w`/`w_din` follow one cycle later, like the activation path.
- **GAP**
  - Entered the cycle after the last `w_re`; that cycle carries the last weight write.
  - Then GAP_CYC further cycles with no writes.
- **RUN**
  - `active`=1 for exactly K*precision consecutive cycles, then go to WAIT_DONE.
  - `mm_done` is ignored in every state except WAIT_DONE.
- **WAIT_DONE**
  - `mm_done`=1: `done` pulses the next cycle, `busy` drops in the same cycle, return to IDLE.
  - TIMEOUT cycles without `mm_done`: `err` pulses, `busy` drops, return to IDLE, `done` is not issued.
- **Timeline** (start sampled at edge 0, K=2, P=4, GAP_CYC=2):
  - `act_re` cycles 1-2; `wr_en_act` 2-3.
  - `w_re` 3-10; `wr_en_w` 4-11.
  - Gap 12-13; `active` 14-21; WAIT_DONE from 22.
- **General form:** first `active` cycle = K + K*P + GAP_CYC + 2.
- **Widths:** counters are sized for K*MAX_P. `w_addr` wraps modulo 2^AW with no error; legal configurations must satisfy K*MAX_P <= 2^AW.
- **Read enables:** `act_re` and `w_re` are never high in the same cycle.
- **Latched config:** `precision` and `exp_set` hold their latched values until the next accepted start.

Test Plan:
- Reset, then start with P=4, exp=15, K=2, N=2:
  - `act_re` at cycles 1-2, `wr_en_w` high for exactly 8 cycles (4-11), `active` high cycles 14-21.
  - With mm_done raised at cycle 30, `done` pulses at 31 and `busy` falls.
- Full integration with `mm`, using the `mm` bench's activation and weight image (precision 4, exp 15):
  - `mm` acc_out after `done` = FFFFC800, FFFFAC00, FFFFA800, FFFF9000.
- Start with precision_in=0 and then 9 -> `err` pulse each time, `busy` stays 0, no memory reads.
- Second start issued during RUN -> ignored; the counts from the first scenario are unchanged and only one `done` pulse occurs.
- mm_done held low -> `err` pulses exactly TIMEOUT cycles after WAIT_DONE entry, no `done`, then a new start is accepted.
- `rst` asserted in LOAD_W cycle 6 -> the next cycle has all outputs 0 and state IDLE; a following start reproduces the timeline of the first scenario exactly.
